// File: rtl/imem_boot_loader.sv
// Boot loader for the single-cycle MIPS instruction memory. It parses a framed byte stream
// (length, big-endian words, XOR checksum), writes the words from address 0 and gates cpu_run.
module imem_boot_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [31:0]     DEPTH   = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = 1;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [31:0]       timer_q, timer_d;
  logic              in_ready_q, in_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              run_q, run_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          len_d   = '0;
          idx_d   = '0;
          bcnt_d  = '0;
          asm_d   = '0;
          chk_d   = '0;
          timer_d = '0;
        end
      end
      S_LEN_HI: if (xfer) begin
        len_d[15:8] = in_data;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_d[7:0] = in_data;
        // bounding N here is what keeps imem_addr from ever wrapping
        if (len_d == 16'd0 || 32'(len_d) > DEPTH) state_d = S_ERROR;
        else                                      state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        chk_d  = chk_q ^ in_data;
        asm_d  = {asm_q[15:0], in_data};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_W-1:0];
          wdata_d = {asm_q, in_data};
          idx_d   = idx_q + IDX_ONE;
          if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = S_CHECK;
        end
      end
      S_CHECK: if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
    // idle-cycle watchdog, active only while the loader is accepting bytes
    if (in_ready_q) begin
      if (xfer) timer_d = '0;
      else begin
        timer_d = timer_q + 32'd1;
        if (TIMEOUT != 0 && timer_q + 32'd1 == 32'(TIMEOUT)) state_d = S_ERROR;
      end
    end
    in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA)   || (state_d == S_CHECK);
    done_d     = (state_d == S_DONE);
    run_d      = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      asm_q      <= asm_d;
      chk_q      <= chk_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed frames plus randomized frames and
// byte gaps, checked against a frame-level reference model.
module tb_imem_boot_loader;
  localparam int AW = 10;
  localparam int TO = 40;
  typedef logic [7:0] b8_t;

  logic          clock = 1'b0;
  logic          reset, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, imem_we, cpu_run, load_done, load_error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;

  imem_boot_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .load_done(load_done), .load_error(load_error));

  always #5 clock = ~clock;

  int total = 0, bad = 0, cyc = 0;
  logic [AW-1:0] got_addr[$], exp_addr[$];
  logic [31:0]   got_data[$], exp_data[$];
  int            got_cyc[$], exp_bi[$], xfer_cyc[$];
  int            exp_res;  // 0 done, 1 error, 2 incomplete
  b8_t           f1[$];
  int            g0[$];

  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (imem_we === 1'b1) begin
    got_addr.push_back(imem_addr); got_data.push_back(imem_wdata); got_cyc.push_back(cyc);
  end

  // Called in the posedge+1 phase; returns in the same phase.
  task automatic send_frame(input b8_t bq[$], input int gq[$], input bit do_start, input int start_at);
    logic acc;
    xfer_cyc.delete(); got_addr.delete(); got_data.delete(); got_cyc.delete();
    if (do_start) begin start = 1'b1; @(posedge clock); #1; start = 1'b0; end
    for (int i = 0; i < bq.size(); i++) begin
      in_valid = 1'b0;
      repeat (gq[i]) begin @(posedge clock); #1; end
      in_valid = 1'b1; in_data = bq[i];
      if (i == start_at) start = 1'b1;
      @(negedge clock); acc = in_ready;
      @(posedge clock); #1; start = 1'b0;
      if (!acc) break;
      xfer_cyc.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  // Frame-level reference: parse the byte list, apply the gap watchdog rule and checksum.
  task automatic model(input b8_t bq[$], input int gq[$]);
    int n; logic [7:0] c; logic [31:0] w;
    exp_addr.delete(); exp_data.delete(); exp_bi.delete();
    exp_res = 2; n = 0; c = 8'h00; w = 32'h0;
    for (int i = 0; i < bq.size(); i++) begin
      if (gq[i] >= TO) begin exp_res = 1; return; end
      if (i == 0) n = int'(bq[0]) * 256;
      else if (i == 1) begin
        n = n + int'(bq[1]);
        if (n == 0 || n > (1 << AW)) begin exp_res = 1; return; end
      end else if (i < 2 + 4 * n) begin
        c = c ^ bq[i]; w = {w[23:0], bq[i]};
        if ((i - 2) % 4 == 3) begin
          exp_addr.push_back(AW'((i - 2) / 4)); exp_data.push_back(w); exp_bi.push_back(i);
        end
      end else begin exp_res = (bq[i] == c) ? 0 : 1; return; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error});
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_good_frame;
    send_frame(f1, g0, 1'b1, -1);
    @(negedge clock);
    total++;
    if (got_addr.size() != 2) begin bad++; $display("FAIL good_nwrites got=%0d want=2", got_addr.size()); end
    else begin
      total++;
      if (got_addr[0] !== 0 || got_data[0] !== 32'h20010005) begin
        bad++; $display("FAIL good_w0 got=%0d:%h want=0:20010005", got_addr[0], got_data[0]);
      end
      total++;
      if (got_addr[1] !== 1 || got_data[1] !== 32'h20020007) begin
        bad++; $display("FAIL good_w1 got=%0d:%h want=1:20020007", got_addr[1], got_data[1]);
      end
      total++;
      if (got_cyc[0] != xfer_cyc[5] || got_cyc[1] != xfer_cyc[9]) begin
        bad++; $display("FAIL good_we_latency got=%0d,%0d want=%0d,%0d",
          got_cyc[0], got_cyc[1], xfer_cyc[5], xfer_cyc[9]);
      end
    end
    total++;
    if ({load_done, cpu_run, load_error, in_ready} !== 4'b1100) begin
      bad++; $display("FAIL good_flags got=%b want=1100", {load_done, cpu_run, load_error, in_ready});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_bad_chk;
    b8_t f[$];
    f = f1; f[10] = 8'h00;
    send_frame(f, g0, 1'b1, -1);
    @(negedge clock);
    total++;
    if (got_addr.size() != 2 || got_data[1] !== 32'h20020007) begin
      bad++; $display("FAIL badchk_writes got=%0d want=2", got_addr.size());
    end
    total++;
    if ({load_done, cpu_run, load_error} !== 3'b001) begin
      bad++; $display("FAIL badchk_flags got=%b want=001", {load_done, cpu_run, load_error});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_bad_len;
    b8_t f[$];
    for (int k = 0; k < 2; k++) begin
      f = f1;
      if (k == 0) begin f[0] = 8'h00; f[1] = 8'h00; end
      else        begin f[0] = 8'h04; f[1] = 8'h01; end
      send_frame(f, g0, 1'b1, -1);
      @(negedge clock);
      total++;
      if (got_addr.size() != 0 || xfer_cyc.size() != 2) begin
        bad++; $display("FAIL badlen%0d_writes got=%0d acc=%0d want=0 acc=2", k, got_addr.size(), xfer_cyc.size());
      end
      total++;
      if ({load_done, cpu_run, load_error, in_ready} !== 4'b0010) begin
        bad++; $display("FAIL badlen%0d_flags got=%b want=0010", k, {load_done, cpu_run, load_error, in_ready});
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_gaps_timeout;
    int g[$];
    for (int k = 0; k < 2; k++) begin
      g.delete();
      for (int i = 0; i < f1.size(); i++) g.push_back($urandom_range(0, TO - 1));
      if (k == 1) g[7] = TO;  // stall once 5 data bytes are in
      model(f1, g);
      send_frame(f1, g, 1'b1, -1);
      @(negedge clock);
      total++;
      if (got_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL gap%0d_nwrites got=%0d want=%0d", k, got_addr.size(), exp_addr.size());
      end else for (int j = 0; j < exp_addr.size(); j++) begin
        total++;
        if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j] || got_cyc[j] != xfer_cyc[exp_bi[j]]) begin
          bad++; $display("FAIL gap%0d_w%0d got=%0d:%h@%0d want=%0d:%h@%0d", k, j, got_addr[j], got_data[j],
            got_cyc[j], exp_addr[j], exp_data[j], xfer_cyc[exp_bi[j]]);
        end
      end
      total++;
      if ({load_done, load_error} !== ((exp_res == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL gap%0d_flags got=%b res=%0d", k, {load_done, load_error}, exp_res);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid;
    b8_t f[$];
    f = f1[0:7];
    send_frame(f, g0, 1'b1, -1);
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0",
        {in_ready, imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error});
    end
    reset = 1'b0;
    repeat (4) @(posedge clock); #1;
    total++;
    if (got_addr.size() != 1 || got_data[0] !== 32'h20010005) begin
      bad++; $display("FAIL midreset_writes got=%0d want=1", got_addr.size());
    end
    test_good_frame();
  endtask

  task automatic test_start_ignored;
    send_frame(f1, g0, 1'b1, 4);
    @(negedge clock);
    total++;
    if (got_addr.size() != 2 || load_done !== 1'b1 || load_error !== 1'b0) begin
      bad++; $display("FAIL startdata got=%0d writes done=%b err=%b want=2 1 0", got_addr.size(), load_done, load_error);
    end
    @(posedge clock); #1;
    start = 1'b1; @(posedge clock); #1; start = 1'b0;
    total++;
    if ({cpu_run, load_done, load_error, in_ready} !== 4'b0001) begin
      bad++; $display("FAIL restart_flags got=%b want=0001", {cpu_run, load_done, load_error, in_ready});
    end
    send_frame(f1, g0, 1'b0, -1);
    @(negedge clock);
    total++;
    if (got_addr.size() != 2 || {load_done, cpu_run} !== 2'b11) begin
      bad++; $display("FAIL restart_done got=%0d writes flags=%b want=2 11", got_addr.size(), {load_done, cpu_run});
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random;
    b8_t f[$]; int g[$]; int n; logic [7:0] c;
    for (int it = 0; it < 30; it++) begin
      f.delete(); g.delete(); c = 8'h00;
      n = $urandom_range(1, 5);
      if ($urandom_range(0, 7) == 0) begin
        f.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'h04);
        f.push_back((f[0] == 8'h00) ? 8'h00 : 8'($urandom_range(1, 255)));
      end else begin
        f.push_back(8'h00); f.push_back(8'(n));
      end
      for (int i = 0; i < 4 * n; i++) begin
        f.push_back(8'($urandom)); c = c ^ f[f.size() - 1];
      end
      f.push_back(($urandom_range(0, 3) == 0) ? (c ^ 8'(1 << $urandom_range(0, 7))) : c);
      for (int i = 0; i < f.size(); i++)
        g.push_back(($urandom_range(0, 24) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 3));
      model(f, g);
      send_frame(f, g, 1'b1, -1);
      @(negedge clock);
      total++;
      if (got_addr.size() != exp_addr.size()) begin
        bad++; $display("FAIL rnd%0d_nwrites got=%0d want=%0d", it, got_addr.size(), exp_addr.size());
      end else for (int j = 0; j < exp_addr.size(); j++) begin
        total++;
        if (got_addr[j] !== exp_addr[j] || got_data[j] !== exp_data[j] || got_cyc[j] != xfer_cyc[exp_bi[j]]) begin
          bad++; $display("FAIL rnd%0d_w%0d got=%0d:%h@%0d want=%0d:%h@%0d", it, j, got_addr[j], got_data[j],
            got_cyc[j], exp_addr[j], exp_data[j], xfer_cyc[exp_bi[j]]);
        end
      end
      total++;
      if ({load_done, cpu_run, load_error} !== ((exp_res == 0) ? 3'b110 : 3'b001)) begin
        bad++; $display("FAIL rnd%0d_flags got=%b res=%0d", it, {load_done, cpu_run, load_error}, exp_res);
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    f1 = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h07, 8'h01};
    g0 = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_bad_len();
    test_gaps_timeout();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
